// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives imem port A and
// the IF/ID register, loads reset/interrupt vectors, injects INT_INSTR.
module fetch_stage #(
   parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
   parameter logic [7:0] INT_VEC_ADDR   = 8'h01,
   parameter logic [7:0] NOP_INSTR      = 8'h00,
   parameter logic [7:0] INT_INSTR      = 8'hF0
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_data,
   input  logic       pc_write_en,
   input  logic       if_id_en,
   input  logic       flush,
   input  logic [7:0] branch_target,
   input  logic       intr,
   output logic [7:0] pc,
   output logic [7:0] id_instr,
   output logic [7:0] id_pc_plus1,
   output logic       id_valid,
   output logic       id_is_int
);

   typedef enum logic [1:0] {
      S_RVEC = 2'd0,
      S_RUN  = 2'd1,
      S_IVEC = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_d;
   logic       pend_q, pend_d, pend_clr;
   logic [7:0] instr_d, plus1_d;
   logic       valid_d, is_int_d;

   // Port-A address: vector slots while loading, otherwise the PC.
   always_comb begin
      imem_addr = pc;
      unique case (state_q)
         S_RVEC:  imem_addr = RESET_VEC_ADDR;
         S_IVEC:  imem_addr = INT_VEC_ADDR;
         default: imem_addr = pc;
      endcase
   end

   // Next-state, next-PC and IF/ID contents in priority order.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc;
      instr_d  = id_instr;
      plus1_d  = id_pc_plus1;
      valid_d  = id_valid;
      is_int_d = id_is_int;
      pend_clr = 1'b0;
      unique case (state_q)
         S_RVEC: begin
            instr_d  = NOP_INSTR;
            plus1_d  = 8'h00;
            valid_d  = 1'b0;
            is_int_d = 1'b0;
            if (pc_write_en) begin
               pc_d    = imem_data;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (flush) begin
               pc_d     = branch_target;
               instr_d  = NOP_INSTR;
               plus1_d  = 8'h00;
               valid_d  = 1'b0;
               is_int_d = 1'b0;
            end else if (pend_q && pc_write_en && if_id_en) begin
               // Return address is the un-fetched PC itself.
               instr_d  = INT_INSTR;
               plus1_d  = pc;
               valid_d  = 1'b1;
               is_int_d = 1'b1;
               state_d  = S_IVEC;
            end else begin
               if (pc_write_en) pc_d = pc + 8'd1;
               if (if_id_en) begin
                  instr_d  = imem_data;
                  plus1_d  = pc + 8'd1;
                  valid_d  = 1'b1;
                  is_int_d = 1'b0;
               end
            end
         end
         S_IVEC: begin
            if (flush) begin
               // Pending stays set so the interrupt is taken again.
               pc_d     = branch_target;
               instr_d  = NOP_INSTR;
               plus1_d  = 8'h00;
               valid_d  = 1'b0;
               is_int_d = 1'b0;
               state_d  = S_RUN;
            end else if (pc_write_en) begin
               pc_d     = imem_data;
               instr_d  = NOP_INSTR;
               plus1_d  = 8'h00;
               valid_d  = 1'b0;
               is_int_d = 1'b0;
               pend_clr = 1'b1;
               state_d  = S_RUN;
            end
         end
         default: state_d = S_RVEC;
      endcase
      // A new request on the clearing edge wins.
      pend_d = (pend_q & ~pend_clr) | intr;
   end

   // State, PC, pending flag and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RVEC;
         pc          <= 8'h00;
         pend_q      <= 1'b0;
         id_instr    <= NOP_INSTR;
         id_pc_plus1 <= 8'h00;
         id_valid    <= 1'b0;
         id_is_int   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc          <= pc_d;
         pend_q      <= pend_d;
         id_instr    <= instr_d;
         id_pc_plus1 <= plus1_d;
         id_valid    <= valid_d;
         id_is_int   <= is_int_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction
// memory model and hand-computed expectations.
module tb_fetch_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic       pc_write_en;
   logic       if_id_en;
   logic       flush;
   logic [7:0] branch_target;
   logic       intr;
   logic [7:0] pc;
   logic [7:0] id_instr;
   logic [7:0] id_pc_plus1;
   logic       id_valid;
   logic       id_is_int;

   logic [7:0] mem [256];
   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .pc_write_en   (pc_write_en),
      .if_id_en      (if_id_en),
      .flush         (flush),
      .branch_target (branch_target),
      .intr          (intr),
      .pc            (pc),
      .id_instr      (id_instr),
      .id_pc_plus1   (id_pc_plus1),
      .id_valid      (id_valid),
      .id_is_int     (id_is_int)
   );

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic [7:0] ins,
                           input logic [7:0] p1, input logic v,
                           input logic ii);
      check({tag, ".instr"}, id_instr, ins);
      check({tag, ".plus1"}, id_pc_plus1, p1);
      check({tag, ".valid"}, {7'd0, id_valid}, {7'd0, v});
      check({tag, ".is_int"}, {7'd0, id_is_int}, {7'd0, ii});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
      mem[8'h00] = 8'h20;
      mem[8'h01] = 8'h80;
      mem[8'h20] = 8'h5A;
      mem[8'h2F] = 8'hA1;
      mem[8'h30] = 8'hB2;
      mem[8'h40] = 8'h77;
      mem[8'h80] = 8'hC3;
      mem[8'h81] = 8'h9D;
      mem[8'h82] = 8'h4E;
      mem[8'hFF] = 8'hE7;

      rst = 1'b1; pc_write_en = 1'b1; if_id_en = 1'b1;
      flush = 1'b0; branch_target = 8'h00; intr = 1'b0;
      step();
      check("rst.pc", pc, 8'h00);
      check("rst.addr", imem_addr, 8'h00);
      check_id("rst", 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      check("rst.addr2", imem_addr, 8'h00);
      step();
      check("rvec.pc", pc, 8'h20);
      check("rvec.addr", imem_addr, 8'h20);
      check("rvec.valid", {7'd0, id_valid}, 8'h00);
      step();
      check_id("first", 8'h5A, 8'h21, 1'b1, 1'b0);
      check("first.pc", pc, 8'h21);

      // Stall with a real instruction held in IF/ID.
      flush = 1'b1; branch_target = 8'h2F;
      step();
      flush = 1'b0;
      check("br2f.pc", pc, 8'h2F);
      step();
      check_id("f2f", 8'hA1, 8'h30, 1'b1, 1'b0);
      pc_write_en = 1'b0; if_id_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         check("stall.pc", pc, 8'h30);
         check_id("stall", 8'hA1, 8'h30, 1'b1, 1'b0);
      end
      pc_write_en = 1'b1; if_id_en = 1'b1;
      step();
      check("unstall.pc", pc, 8'h31);
      check_id("unstall", 8'hB2, 8'h31, 1'b1, 1'b0);

      // Flush beats stall.
      flush = 1'b1; branch_target = 8'h40;
      pc_write_en = 1'b0; if_id_en = 1'b0;
      step();
      flush = 1'b0; pc_write_en = 1'b1; if_id_en = 1'b1;
      check("flush.pc", pc, 8'h40);
      check_id("flush", 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      check_id("f40", 8'h77, 8'h41, 1'b1, 1'b0);

      // Interrupt sampled on the edge that lands pc at 0x10.
      flush = 1'b1; branch_target = 8'h10; intr = 1'b1;
      step();
      flush = 1'b0; intr = 1'b0;
      check("i.pc", pc, 8'h10);
      step();
      check_id("inj", 8'hF0, 8'h10, 1'b1, 1'b1);
      check("inj.pc", pc, 8'h10);
      check("inj.addr", imem_addr, 8'h01);
      step();
      check("ivec.pc", pc, 8'h80);
      check_id("ivec", 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      check_id("isr", 8'hC3, 8'h81, 1'b1, 1'b0);
      step();
      check_id("nopend", 8'h9D, 8'h82, 1'b1, 1'b0);

      // Flush while loading the interrupt vector.
      intr = 1'b1;
      step();
      intr = 1'b0;
      check_id("f82", 8'h4E, 8'h83, 1'b1, 1'b0);
      step();
      check_id("inj2", 8'hF0, 8'h83, 1'b1, 1'b1);
      flush = 1'b1; branch_target = 8'h55;
      step();
      flush = 1'b0;
      check("ivfl.pc", pc, 8'h55);
      check("ivfl.valid", {7'd0, id_valid}, 8'h00);
      step();
      check_id("reinj", 8'hF0, 8'h55, 1'b1, 1'b1);
      check("reinj.pc", pc, 8'h55);
      step();
      check("ivec2.pc", pc, 8'h80);
      step();
      check_id("isr2", 8'hC3, 8'h81, 1'b1, 1'b0);

      // PC wrap.
      flush = 1'b1; branch_target = 8'hFF;
      step();
      flush = 1'b0;
      check("bff.pc", pc, 8'hFF);
      step();
      check("wrap.pc", pc, 8'h00);
      check_id("wrap", 8'hE7, 8'h00, 1'b1, 1'b0);

      // Reset while loading the interrupt vector.
      intr = 1'b1;
      step();
      intr = 1'b0;
      check_id("f00", 8'h20, 8'h01, 1'b1, 1'b0);
      step();
      check_id("inj3", 8'hF0, 8'h01, 1'b1, 1'b1);
      check("inj3.addr", imem_addr, 8'h01);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst.pc", pc, 8'h00);
      check("mrst.addr", imem_addr, 8'h00);
      check_id("mrst", 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      check("mrst.rvec", pc, 8'h20);
      step();
      check_id("mrst.first", 8'h5A, 8'h21, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
